// File: rtl/div_pkg.sv
// Shared definitions for the sequential non-restoring divider.
//   div_state_t        : controller states (IDLE, RUN, FIX, DONE)
//   DIV_WIDTH_DEFAULT  : default operand width
package div_pkg;

    localparam int unsigned DIV_WIDTH_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_t;

endpackage : div_pkg

// File: rtl/cas_row.sv
// One row of controlled add/subtract cells.
//   a, b  : N-bit operands
//   sub   : 0 -> s = a + b, 1 -> s = a - b (two's complement)
//   s     : N-bit result
//   cout  : carry out of the top cell
module cas_row #(
    parameter int unsigned N = 9
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         sub,
    output logic [N-1:0] s,
    output logic         cout
);

    logic [N:0] sum;

    // Subtraction is addition of the inverted operand with the carry-in set.
    assign sum  = {1'b0, a} + {1'b0, b ^ {N{sub}}} + {{N{1'b0}}, sub};
    assign s    = sum[N-1:0];
    assign cout = sum[N];

endmodule : cas_row

// File: rtl/seq_nonrestoring_divider.sv
// Sequential unsigned non-restoring divider, one quotient bit per clock.
// A single CAS row is reused for every iteration and for the final
// remainder correction.
//   clk, rst            : clock, synchronous active-high reset
//   start               : request, honoured only when not busy
//   dividend, divisor   : operands, captured in the accepting cycle
//   busy                : division in progress (RUN or FIX)
//   done                : one-cycle pulse when a result becomes valid
//   quotient, remainder : registered results, held until the next result
//   div_by_zero         : registered flag, set with a divide-by-zero result
module seq_nonrestoring_divider
    import div_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    div_state_t       state, state_next;
    logic [CW-1:0]    cnt;
    logic [WIDTH:0]   a_reg;      // partial remainder, two's complement
    logic [WIDTH-1:0] q_reg;      // dividend shifting out, quotient shifting in
    logic [WIDTH:0]   m_reg;      // zero-extended divisor

    logic [WIDTH:0]   cas_a;
    logic [WIDTH:0]   cas_s;
    logic             cas_sub;
    logic             unused_cout;
    logic             accept;
    logic             divisor_zero;

    assign divisor_zero = (divisor == '0);
    assign accept       = start && ((state == IDLE) || (state == DONE));

    // RUN: shift {A,Q} left one place, then subtract M while A is
    // non-negative, add it back while A is negative.
    // FIX: a negative final A is restored by one addition of M.
    always_comb begin
        cas_a   = {a_reg[WIDTH-1:0], q_reg[WIDTH-1]};
        cas_sub = ~a_reg[WIDTH];
        if (state == FIX) begin
            cas_a   = a_reg;
            cas_sub = 1'b0;
        end
    end

    cas_row #(
        .N (WIDTH + 1)
    ) u_cas_row (
        .a    (cas_a),
        .b    (m_reg),
        .sub  (cas_sub),
        .s    (cas_s),
        .cout (unused_cout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = divisor_zero ? DONE : RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (cnt == CW'(1)) begin
                    state_next = FIX;
                end
            end
            FIX: begin
                busy       = 1'b1;
                state_next = DONE;
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
                if (start) begin
                    state_next = divisor_zero ? DONE : RUN;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt         <= '0;
            a_reg       <= '0;
            q_reg       <= '0;
            m_reg       <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (accept) begin
                        if (divisor_zero) begin
                            quotient    <= '1;
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                        end else begin
                            a_reg <= '0;
                            q_reg <= dividend;
                            m_reg <= {1'b0, divisor};
                            cnt   <= CW'(WIDTH);
                        end
                    end
                end
                RUN: begin
                    a_reg <= cas_s;
                    q_reg <= {q_reg[WIDTH-2:0], ~cas_s[WIDTH]};
                    cnt   <= cnt - CW'(1);
                end
                FIX: begin
                    if (a_reg[WIDTH]) begin
                        a_reg     <= cas_s;
                        remainder <= cas_s[WIDTH-1:0];
                    end else begin
                        remainder <= a_reg[WIDTH-1:0];
                    end
                    quotient    <= q_reg;
                    div_by_zero <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule : seq_nonrestoring_divider

// File: tb/tb_seq_nonrestoring_divider.sv
module tb_seq_nonrestoring_divider;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    int checks = 0;
    int errors = 0;

    seq_nonrestoring_divider #(
        .WIDTH (W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drives one request starting just after an edge and watches a fixed
    // window of cycles, sampling on the falling edge. k counts edges after
    // the edge the request was raised at. Optional extra start pulse at
    // inject_k and a one-cycle reset at rst_k (0 disables either).
    task automatic run_op(input logic [W-1:0] dd, input logic [W-1:0] dv,
                          input int inject_k, input int rst_k, input int window,
                          output int first_done, output int n_done, output int n_busy,
                          output logic [W-1:0] q_got, output logic [W-1:0] r_got,
                          output logic dbz_got);
        start    = 1'b1;
        dividend = dd;
        divisor  = dv;
        first_done = 0;
        n_done     = 0;
        n_busy     = 0;
        q_got      = '0;
        r_got      = '0;
        dbz_got    = 1'b0;
        for (int k = 1; k <= window; k++) begin
            @(posedge clk);
            #1;
            if (k == 1) begin
                start    = 1'b0;
                dividend = W'($urandom);
                divisor  = W'($urandom);
            end
            if (k == inject_k) begin
                start    = 1'b1;
                dividend = W'($urandom);
                divisor  = W'($urandom) | W'(1);
            end else if (k == inject_k + 1) begin
                start = 1'b0;
            end
            rst = (k == rst_k);
            @(negedge clk);
            if (busy) n_busy++;
            if (done) begin
                n_done++;
                if (first_done == 0) begin
                    first_done = k;
                    q_got      = quotient;
                    r_got      = remainder;
                    dbz_got    = div_by_zero;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        start = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({busy, done, div_by_zero} !== 3'b000) begin
            errors++;
            $display("FAIL reset_flags busy/done/dbz got %b%b%b want 000", busy, done, div_by_zero);
        end
        checks++;
        if ({quotient, remainder} !== '0) begin
            errors++;
            $display("FAIL reset_results q=%0d r=%0d want 0 0", quotient, remainder);
        end
        @(posedge clk);
        #1;
    endtask

    // Directed operands with full timing checks against plain arithmetic.
    task automatic test_directed();
        logic [W-1:0] dd_tab [5] = '{8'd100, 8'd255, 8'd5, 8'd200, 8'd0};
        logic [W-1:0] dv_tab [5] = '{8'd7,   8'd1,   8'd9, 8'd200, 8'd13};
        int fd, nd, nb;
        logic [W-1:0] qg, rg;
        logic dz;
        for (int i = 0; i < 5; i++) begin
            run_op(dd_tab[i], dv_tab[i], 0, 0, W + 5, fd, nd, nb, qg, rg, dz);
            checks++;
            if (qg !== W'(int'(dd_tab[i]) / int'(dv_tab[i])) || rg !== W'(int'(dd_tab[i]) % int'(dv_tab[i])) || dz !== 1'b0) begin
                errors++;
                $display("FAIL directed_result %0d/%0d got q=%0d r=%0d dbz=%b want q=%0d r=%0d dbz=0",
                         dd_tab[i], dv_tab[i], qg, rg, dz, int'(dd_tab[i]) / int'(dv_tab[i]), int'(dd_tab[i]) % int'(dv_tab[i]));
            end
            checks++;
            if (fd !== W + 2 || nd !== 1) begin
                errors++;
                $display("FAIL directed_latency %0d/%0d got done_at=%0d pulses=%0d want %0d 1", dd_tab[i], dv_tab[i], fd, nd, W + 2);
            end
            checks++;
            if (nb !== W + 1) begin
                errors++;
                $display("FAIL directed_busy %0d/%0d got %0d cycles want %0d", dd_tab[i], dv_tab[i], nb, W + 1);
            end
        end
    endtask

    task automatic test_div_by_zero();
        int fd, nd, nb;
        logic [W-1:0] qg, rg;
        logic dz;
        run_op(8'd77, 8'd0, 0, 0, 5, fd, nd, nb, qg, rg, dz);
        checks++;
        if (qg !== 8'hFF || rg !== 8'd77 || dz !== 1'b1) begin
            errors++;
            $display("FAIL dbz_result got q=%0h r=%0d dbz=%b want ff 77 1", qg, rg, dz);
        end
        checks++;
        if (fd !== 1 || nd !== 1 || nb !== 0) begin
            errors++;
            $display("FAIL dbz_timing got done_at=%0d pulses=%0d busy=%0d want 1 1 0", fd, nd, nb);
        end
    endtask

    task automatic test_start_while_busy();
        int fd, nd, nb;
        logic [W-1:0] qg, rg;
        logic dz;
        run_op(8'd100, 8'd7, 4, 0, W + 5, fd, nd, nb, qg, rg, dz);
        checks++;
        if (qg !== 8'd14 || rg !== 8'd2 || dz !== 1'b0) begin
            errors++;
            $display("FAIL busy_start_result got q=%0d r=%0d dbz=%b want 14 2 0", qg, rg, dz);
        end
        checks++;
        if (nd !== 1 || fd !== W + 2 || nb !== W + 1) begin
            errors++;
            $display("FAIL busy_start_timing got pulses=%0d done_at=%0d busy=%0d want 1 %0d %0d", nd, fd, nb, W + 2, W + 1);
        end
    endtask

    task automatic test_reset_mid_run();
        int fd, nd, nb;
        logic [W-1:0] qg, rg;
        logic dz;
        run_op(8'd201, 8'd4, 0, 4, W + 5, fd, nd, nb, qg, rg, dz);
        checks++;
        if (nd !== 0 || nb !== 4) begin
            errors++;
            $display("FAIL midrst_abort got pulses=%0d busy=%0d want 0 4", nd, nb);
        end
        checks++;
        if (quotient !== '0 || remainder !== '0 || div_by_zero !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL midrst_outputs got q=%0d r=%0d dbz=%b busy=%b want 0 0 0 0", quotient, remainder, div_by_zero, busy);
        end
        run_op(8'd9, 8'd3, 0, 0, W + 5, fd, nd, nb, qg, rg, dz);
        checks++;
        if (qg !== 8'd3 || rg !== 8'd0 || fd !== W + 2) begin
            errors++;
            $display("FAIL midrst_recover got q=%0d r=%0d done_at=%0d want 3 0 %0d", qg, rg, fd, W + 2);
        end
    endtask

    task automatic test_back_to_back();
        int held_bad = 0;
        int done_bad = 0;
        int nb = 0;
        logic [W-1:0] q2 = '0, r2 = '0;
        start    = 1'b1;
        dividend = 8'd100;
        divisor  = 8'd7;
        for (int k = 1; k <= 2 * (W + 2) + 2; k++) begin
            @(posedge clk);
            #1;
            if (k == 1) start = 1'b0;
            if (k == W + 2) begin
                start    = 1'b1;
                dividend = 8'd50;
                divisor  = 8'd6;
            end else if (k == W + 3) begin
                start = 1'b0;
            end
            @(negedge clk);
            if (k > W + 2 && busy) nb++;
            if (done !== (k == W + 2 || k == 2 * (W + 2))) done_bad++;
            if (k >= W + 2 && k < 2 * (W + 2) && (quotient !== 8'd14 || remainder !== 8'd2)) held_bad++;
            if (k == 2 * (W + 2)) begin
                q2 = quotient;
                r2 = remainder;
            end
        end
        @(posedge clk);
        #1;
        checks++;
        if (q2 !== 8'd8 || r2 !== 8'd2) begin
            errors++;
            $display("FAIL b2b_result got q=%0d r=%0d want 8 2", q2, r2);
        end
        checks++;
        if (held_bad !== 0) begin
            errors++;
            $display("FAIL b2b_hold got %0d cycles without 14 rem 2 want 0", held_bad);
        end
        checks++;
        if (done_bad !== 0 || nb !== W + 1) begin
            errors++;
            $display("FAIL b2b_timing got done_errs=%0d busy=%0d want 0 %0d", done_bad, nb, W + 1);
        end
    endtask

    task automatic test_random();
        int fd, nd, nb;
        logic [W-1:0] qg, rg, dd, dv, eq, er;
        logic dz, edz;
        int elat, ebusy;
        for (int i = 0; i < 40; i++) begin
            dd = W'($urandom);
            dv = ($urandom_range(0, 7) == 0) ? W'(0) : W'($urandom_range(1, 255));
            if (dv == 0) begin
                eq = '1; er = dd; edz = 1'b1; elat = 1; ebusy = 0;
            end else begin
                eq = W'(int'(dd) / int'(dv)); er = W'(int'(dd) % int'(dv));
                edz = 1'b0; elat = W + 2; ebusy = W + 1;
            end
            run_op(dd, dv, 0, 0, W + 5, fd, nd, nb, qg, rg, dz);
            checks++;
            if (qg !== eq || rg !== er || dz !== edz) begin
                errors++;
                $display("FAIL rand_result %0d/%0d got q=%0d r=%0d dbz=%b want q=%0d r=%0d dbz=%b", dd, dv, qg, rg, dz, eq, er, edz);
            end
            checks++;
            if (fd !== elat || nd !== 1 || nb !== ebusy) begin
                errors++;
                $display("FAIL rand_timing %0d/%0d got done_at=%0d pulses=%0d busy=%0d want %0d 1 %0d", dd, dv, fd, nd, nb, elat, ebusy);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_div_by_zero();
        test_start_while_busy();
        test_reset_mid_run();
        test_div_by_zero();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_seq_nonrestoring_divider
